// File: rtl/s298_ctl_pkg.sv
// Shared definitions for the s298 query sequencer.
// Contents:
//   - default frame widths (NIN_D, NOUT_D) and the flush pattern (FLUSH_PAT_D)
//   - state encoding (state_t plus ST_* constants)
//   - is_dut_active(): true in the states that clock the benchmark
package s298_ctl_pkg;

  localparam int         NIN_D       = 3;
  localparam int         NOUT_D      = 6;
  localparam logic [2:0] FLUSH_PAT_D = 3'b001;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_KSHIFT = 3'd1;
  localparam state_t ST_FLUSH  = 3'd2;
  localparam state_t ST_RUN    = 3'd3;
  localparam state_t ST_RESP   = 3'd4;

  // The benchmark is only clocked while it is being flushed or driven with frames.
  function automatic logic is_dut_active(input state_t st);
    return (st == ST_FLUSH) || (st == ST_RUN);
  endfunction

endpackage

// File: rtl/s298_frame_capture.sv
// Capture buffer of MAXLEN slots, each NOUT bits wide.
// Each slot is written in place by its index; nothing ever shifts.
// Ports:
//   i_ck, i_rn  clock and asynchronous active-low reset
//   i_clr       zero every slot
//   i_we        write i_din into slot i_idx
//   i_idx       slot index for the write
//   i_din       output frame to store
//   o_data      all slots; slot k sits at bits [k*NOUT +: NOUT]
module s298_frame_capture
  import s298_ctl_pkg::*;
#(
  parameter int NOUT   = NOUT_D,
  parameter int MAXLEN = 16,
  parameter int IDXW   = $clog2(MAXLEN)
)(
  input  logic                   i_ck,
  input  logic                   i_rn,
  input  logic                   i_clr,
  input  logic                   i_we,
  input  logic [IDXW-1:0]        i_idx,
  input  logic [NOUT-1:0]        i_din,
  output logic [MAXLEN*NOUT-1:0] o_data
);

  localparam int BW = $clog2(MAXLEN*NOUT);

  logic [MAXLEN*NOUT-1:0] r_data;
  logic [BW-1:0]          w_base;

  assign w_base = BW'(i_idx) * BW'(NOUT);

  // Slot storage: clear takes priority over a write.
  always_ff @(posedge i_ck or negedge i_rn) begin
    if (!i_rn) begin
      r_data <= {(MAXLEN*NOUT){1'b0}};
    end else if (i_clr) begin
      r_data <= {(MAXLEN*NOUT){1'b0}};
    end else if (i_we) begin
      r_data[w_base +: NOUT] <= i_din;
    end
  end

  assign o_data = r_data;

endmodule

// File: rtl/s298_query_seq.sv
// Sequencer that drives one locked s298 instance as an oracle.
// It shifts a key into the key scan chain and flushes the benchmark to a
// known state. It then applies a queued list of input frames and returns
// the output frame captured in every cycle as one response.
// Ports:
//   i_ck, i_rn                     clock and asynchronous active-low reset
//   i_key_valid/i_key_data         key request; o_key_ready accepts it
//   o_key_loaded                   a complete key is in the chain
//   i_q_valid/i_q_len/i_q_frames   query request; o_q_ready accepts it
//   o_dut_in/i_dut_out/o_dut_en    benchmark data inputs, outputs, clock enable
//   o_dut_key_se/o_dut_key_si      key scan enable and data
//   o_r_valid/i_r_ready            response handshake
//   o_r_data/o_r_len/o_r_err       captured frames, frame count, length clamped
//   o_busy                         not idle
module s298_query_seq
  import s298_ctl_pkg::*;
#(
  parameter int             NIN       = NIN_D,
  parameter int             NOUT      = NOUT_D,
  parameter int             KEYW      = 16,
  parameter int             MAXLEN    = 16,
  parameter int             LENW      = 5,
  parameter int             FLUSH_CYC = 2,
  parameter logic [NIN-1:0] FLUSH_PAT = NIN'(FLUSH_PAT_D)
)(
  input  logic                   i_ck,
  input  logic                   i_rn,
  input  logic                   i_key_valid,
  input  logic [KEYW-1:0]        i_key_data,
  output logic                   o_key_ready,
  output logic                   o_key_loaded,
  input  logic                   i_q_valid,
  input  logic [LENW-1:0]        i_q_len,
  input  logic [MAXLEN*NIN-1:0]  i_q_frames,
  output logic                   o_q_ready,
  output logic [NIN-1:0]         o_dut_in,
  input  logic [NOUT-1:0]        i_dut_out,
  output logic                   o_dut_en,
  output logic                   o_dut_key_se,
  output logic                   o_dut_key_si,
  output logic                   o_r_valid,
  input  logic                   i_r_ready,
  output logic [MAXLEN*NOUT-1:0] o_r_data,
  output logic [LENW-1:0]        o_r_len,
  output logic                   o_r_err,
  output logic                   o_busy
);

  localparam int KIW   = $clog2(KEYW);
  localparam int CIW   = $clog2(MAXLEN);
  localparam int FIDXW = $clog2(MAXLEN*NIN);

  localparam logic [LENW-1:0] KEY_LAST   = LENW'(KEYW-1);
  localparam logic [LENW-1:0] FLUSH_LAST = LENW'(FLUSH_CYC-1);
  localparam logic [LENW-1:0] LEN_MAX    = LENW'(MAXLEN);
  localparam logic [LENW-1:0] CNT_ZERO   = {LENW{1'b0}};
  localparam logic [LENW-1:0] CNT_ONE    = LENW'(1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [LENW-1:0]       r_cnt;
  logic [LENW-1:0]       w_cnt_nxt;
  logic [LENW-1:0]       r_len;
  logic                  r_err;
  logic                  r_key_loaded;
  logic [KEYW-1:0]       r_key;
  logic [MAXLEN*NIN-1:0] r_frames;

  logic                  w_idle;
  logic                  w_key_acc;
  logic                  w_q_acc;
  logic                  w_key_done;
  logic                  w_len_over;
  logic [LENW-1:0]       w_len_clamp;
  logic [KIW-1:0]        w_key_idx;
  logic [FIDXW-1:0]      w_fbase;
  logic [NIN-1:0]        w_frame;
  logic                  w_cap_we;

  assign w_idle     = (r_state == ST_IDLE);
  // A key request always wins over a query presented in the same cycle.
  assign w_key_acc  = w_idle & i_key_valid;
  assign w_q_acc    = w_idle & i_q_valid & r_key_loaded & ~i_key_valid;
  assign w_key_done = (r_state == ST_KSHIFT) && (r_cnt == KEY_LAST);

  assign w_len_over  = (i_q_len > LEN_MAX);
  assign w_len_clamp = w_len_over ? LEN_MAX : i_q_len;

  // The key goes out MSB first, so shift cycle i presents bit KEYW-1-i.
  assign w_key_idx = KIW'(KEY_LAST - r_cnt);
  assign w_fbase   = FIDXW'(r_cnt) * FIDXW'(NIN);
  assign w_frame   = r_frames[w_fbase +: NIN];
  assign w_cap_we  = (r_state == ST_RUN);

  // Next state and the shared cycle counter. Each phase ends on an exact compare.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = CNT_ZERO;
        if (w_key_acc) begin
          w_state_nxt = ST_KSHIFT;
        end else if (w_q_acc) begin
          w_state_nxt = ST_FLUSH;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_KSHIFT: begin
        if (r_cnt == KEY_LAST) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = CNT_ZERO;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      ST_FLUSH: begin
        if (r_cnt == FLUSH_LAST) begin
          w_cnt_nxt = CNT_ZERO;
          if (r_len == CNT_ZERO) begin
            w_state_nxt = ST_RESP;
          end else begin
            w_state_nxt = ST_RUN;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      ST_RUN: begin
        // r_len is at least 1 here; a zero-length query skips RUN.
        if (r_cnt == (r_len - CNT_ONE)) begin
          w_state_nxt = ST_RESP;
          w_cnt_nxt   = CNT_ZERO;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      ST_RESP: begin
        if (i_r_ready) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_RESP;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = CNT_ZERO;
      end
    endcase
  end

  // State and request latches. Any reset drops KEY_LOADED because the chain is then unknown.
  always_ff @(posedge i_ck or negedge i_rn) begin
    if (!i_rn) begin
      r_state      <= ST_IDLE;
      r_cnt        <= CNT_ZERO;
      r_len        <= CNT_ZERO;
      r_err        <= 1'b0;
      r_key_loaded <= 1'b0;
      r_key        <= {KEYW{1'b0}};
      r_frames     <= {(MAXLEN*NIN){1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_key_acc) begin
        r_key        <= i_key_data;
        r_key_loaded <= 1'b0;
      end else if (w_key_done) begin
        r_key_loaded <= 1'b1;
      end
      if (w_q_acc) begin
        r_frames <= i_q_frames;
        r_len    <= w_len_clamp;
        r_err    <= w_len_over;
      end
    end
  end

  // Benchmark, scan and response strobes decoded from the registered state.
  always_comb begin
    o_dut_in     = {NIN{1'b0}};
    o_dut_key_se = 1'b0;
    o_dut_key_si = 1'b0;
    o_r_valid    = 1'b0;
    o_busy       = 1'b1;
    case (r_state)
      ST_IDLE: begin
        o_busy = 1'b0;
      end
      ST_KSHIFT: begin
        o_dut_key_se = 1'b1;
        o_dut_key_si = r_key[w_key_idx];
      end
      ST_FLUSH: begin
        o_dut_in = FLUSH_PAT;
      end
      ST_RUN: begin
        o_dut_in = w_frame;
      end
      ST_RESP: begin
        o_r_valid = 1'b1;
      end
      default: begin
        o_busy = 1'b0;
      end
    endcase
  end

  assign o_dut_en     = is_dut_active(r_state);
  // Gate with RN so that KEY_READY also reads 0 while reset is held.
  assign o_key_ready  = w_key_acc & i_rn;
  assign o_q_ready    = w_q_acc;
  assign o_key_loaded = r_key_loaded;
  assign o_r_len      = r_len;
  assign o_r_err      = r_err;

  // The capture buffer is cleared on query accept, so slots past LEN read 0.
  s298_frame_capture #(
    .NOUT   (NOUT),
    .MAXLEN (MAXLEN),
    .IDXW   (CIW)
  ) u_capture (
    .i_ck   (i_ck),
    .i_rn   (i_rn),
    .i_clr  (w_q_acc),
    .i_we   (w_cap_we),
    .i_idx  (r_cnt[CIW-1:0]),
    .i_din  (i_dut_out),
    .o_data (o_r_data)
  );

endmodule

// File: tb/tb_s298_query_seq.sv
// Directed bench for s298_query_seq.
// A stand-in benchmark is attached to the sequencer. Its output frame is a
// 6-bit state that shifts in each 3-bit input frame while enabled, and it
// keeps a key shift register fed from the scan port. Expected values are
// worked out by hand from that stand-in, or by the small predictor function.
module tb_s298_query_seq;

  logic         ck = 1'b0;
  logic         rn = 1'b0;
  logic         key_valid;
  logic [15:0]  key_data;
  logic         key_ready;
  logic         key_loaded;
  logic         q_valid;
  logic [4:0]   q_len;
  logic [47:0]  q_frames;
  logic         q_ready;
  logic [2:0]   dut_in;
  logic [5:0]   dut_out;
  logic         dut_en;
  logic         dut_key_se;
  logic         dut_key_si;
  logic         r_valid;
  logic         r_ready;
  logic [95:0]  r_data;
  logic [4:0]   r_len;
  logic         r_err;
  logic         busy;

  logic [5:0]   m_state;
  logic [15:0]  m_chain;
  logic [112:0] w_outs;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 ck = ~ck;

  s298_query_seq u_dut (
    .i_ck         (ck),
    .i_rn         (rn),
    .i_key_valid  (key_valid),
    .i_key_data   (key_data),
    .o_key_ready  (key_ready),
    .o_key_loaded (key_loaded),
    .i_q_valid    (q_valid),
    .i_q_len      (q_len),
    .i_q_frames   (q_frames),
    .o_q_ready    (q_ready),
    .o_dut_in     (dut_in),
    .i_dut_out    (dut_out),
    .o_dut_en     (dut_en),
    .o_dut_key_se (dut_key_se),
    .o_dut_key_si (dut_key_si),
    .o_r_valid    (r_valid),
    .i_r_ready    (r_ready),
    .o_r_data     (r_data),
    .o_r_len      (r_len),
    .o_r_err      (r_err),
    .o_busy       (busy)
  );

  // Stand-in benchmark state and key chain.
  always_ff @(posedge ck or negedge rn) begin
    if (!rn) begin
      m_state <= 6'd0;
      m_chain <= 16'd0;
    end else begin
      if (dut_en) m_state <= {m_state[2:0], dut_in};
      if (dut_key_se) m_chain <= {m_chain[14:0], dut_key_si};
    end
  end
  assign dut_out = m_state;

  assign w_outs = {key_ready, key_loaded, q_ready, dut_in, dut_en, dut_key_se,
                   dut_key_si, r_valid, r_data, r_len, r_err, busy};

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge ck);
    #2;
  endtask

  // Expected response: flush twice with 001, then slot k holds the state before frame k.
  function automatic logic [95:0] predict(input logic [47:0] fr, input int len);
    logic [5:0]  st;
    logic [95:0] r;
    st = 6'd0;
    r  = 96'd0;
    for (int k = 0; k < 2; k++) st = {st[2:0], 3'b001};
    for (int k = 0; k < len; k++) begin
      r  = r | (96'(st) << (6 * k));
      st = {st[2:0], 3'(fr >> (3 * k))};
    end
    return r;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before the end of the run");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] exp_si;
    logic [14:0] exp_in;
    logic [47:0] fr;
    int          n;
    int          n_en;

    key_valid = 1'b0; key_data = 16'd0; q_valid = 1'b0; q_len = 5'd0;
    q_frames = 48'd0; r_ready = 1'b0;

    // Reset state.
    repeat (3) @(posedge ck);
    #1;
    chk("rst_outs", 128'(w_outs), 128'd0);
    rn = 1'b1;

    // A query with no key loaded is refused.
    step(); q_valid = 1'b1; q_len = 5'd1; #1;
    chk("q_no_key", 128'(q_ready), 128'd0);

    // Key load of A5C3, MSB first.
    step(); q_valid = 1'b0; key_valid = 1'b1; key_data = 16'hA5C3; #1;
    chk("key_ready", 128'(key_ready), 128'd1);
    step(); key_valid = 1'b0; key_data = 16'h0000;
    exp_si = 16'b1010_0101_1100_0011;
    for (int i = 0; i < 16; i++) begin
      #1;
      chk("key_se", 128'(dut_key_se), 128'd1);
      chk("key_si", 128'(dut_key_si), 128'(exp_si[15]));
      if (i == 0) begin
        chk("key_en_off", 128'(dut_en), 128'd0);
        chk("key_loaded_low", 128'(key_loaded), 128'd0);
      end
      exp_si = exp_si << 1;
      step();
    end
    #1;
    chk("key_se_end", 128'(dut_key_se), 128'd0);
    chk("key_loaded", 128'(key_loaded), 128'd1);
    chk("key_chain", 128'(m_chain), 128'h A5C3);

    // Basic query: three frames, response in cycle t+6.
    step(); r_ready = 1'b1; q_valid = 1'b1; q_len = 5'd3;
    q_frames = 48'(9'b110_100_010); #1;
    chk("q_ready", 128'(q_ready), 128'd1);
    step(); q_valid = 1'b0; q_frames = 48'd0;
    exp_in = 15'b001_001_010_100_110;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("q_dut_in", 128'(dut_in), 128'(exp_in[14:12]));
      chk("q_dut_en", 128'(dut_en), 128'd1);
      chk("q_rvalid_early", 128'(r_valid), 128'd0);
      exp_in = exp_in << 3;
      step();
    end
    #1;
    chk("q_rvalid", 128'(r_valid), 128'd1);
    chk("q_rlen", 128'(r_len), 128'd3);
    chk("q_rerr", 128'(r_err), 128'd0);
    chk("q_rdata", 128'(r_data), 128'(18'b010100_001010_001001));
    step(); #1;
    chk("q_idle", 128'(busy), 128'd0);

    // Key and query together: key wins, query taken right after the shift.
    step(); key_valid = 1'b1; key_data = 16'h1234; q_valid = 1'b1; q_len = 5'd1;
    q_frames = 48'(3'b111); #1;
    chk("sim_key_ready", 128'(key_ready), 128'd1);
    chk("sim_q_ready0", 128'(q_ready), 128'd0);
    step(); key_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      #1;
      if (i == 5) chk("sim_q_shift", 128'(q_ready), 128'd0);
      step();
    end
    #1;
    chk("sim_q_ready1", 128'(q_ready), 128'd1);
    chk("sim_key_loaded", 128'(key_loaded), 128'd1);
    chk("sim_chain", 128'(m_chain), 128'h1234);
    step(); q_valid = 1'b0; #1;
    n = 0;
    while (!r_valid && n < 40) begin step(); #1; n++; end
    chk("sim_lat", 128'(n), 128'd3);
    chk("sim_rlen", 128'(r_len), 128'd1);
    chk("sim_rdata", 128'(r_data), 128'(6'b001001));
    step(); #1;
    chk("sim_idle", 128'(busy), 128'd0);

    // Backpressure: response held for five cycles, released on the sixth.
    step(); r_ready = 1'b0; q_valid = 1'b1; q_len = 5'd2; q_frames = 48'(6'b101_011);
    step(); q_valid = 1'b0; #1;
    n = 0;
    while (!r_valid && n < 40) begin step(); #1; n++; end
    chk("bp_lat", 128'(n), 128'd4);
    for (int i = 0; i < 5; i++) begin
      chk("bp_rvalid", 128'(r_valid), 128'd1);
      chk("bp_rdata", 128'(r_data), 128'(12'b001011_001001));
      chk("bp_rlen", 128'(r_len), 128'd2);
      if (i == 2) begin
        key_valid = 1'b1; q_valid = 1'b1; #1;
        chk("bp_key_refused", 128'(key_ready), 128'd0);
        chk("bp_q_refused", 128'(q_ready), 128'd0);
        key_valid = 1'b0; q_valid = 1'b0;
      end
      step(); #1;
    end
    r_ready = 1'b1; #1;
    chk("bp_rvalid6", 128'(r_valid), 128'd1);
    step(); #1;
    chk("bp_idle", 128'(busy), 128'd0);

    // Over-long query: clamped to 16 frames with R_ERR.
    fr = 48'd0;
    for (int k = 0; k < 16; k++) fr = fr | (48'(k & 7) << (3 * k));
    step(); q_valid = 1'b1; q_len = 5'd20; q_frames = fr; #1;
    chk("long_q_ready", 128'(q_ready), 128'd1);
    step(); q_valid = 1'b0; #1;
    n = 0; n_en = 0;
    while (!r_valid && n < 60) begin
      if (dut_en) n_en++;
      step(); #1; n++;
    end
    chk("long_en_cycles", 128'(n_en), 128'd18);
    chk("long_rlen", 128'(r_len), 128'd16);
    chk("long_rerr", 128'(r_err), 128'd1);
    chk("long_rdata", 128'(r_data), 128'(predict(fr, 16)));
    step();

    // Zero-length query: flush only, response in cycle t+3.
    q_valid = 1'b1; q_len = 5'd0; q_frames = fr;
    step(); q_valid = 1'b0; #1;
    n = 0; n_en = 0;
    while (!r_valid && n < 40) begin
      if (dut_en) n_en++;
      step(); #1; n++;
    end
    chk("zero_lat", 128'(n), 128'd2);
    chk("zero_en_cycles", 128'(n_en), 128'd2);
    chk("zero_rlen", 128'(r_len), 128'd0);
    chk("zero_rdata", 128'(r_data), 128'd0);
    chk("zero_rerr", 128'(r_err), 128'd0);
    step();

    // Reset in the middle of RUN.
    q_valid = 1'b1; q_len = 5'd5; q_frames = fr;
    step(); q_valid = 1'b0;
    step(); step(); #1;
    chk("mid_run_en", 128'(dut_en), 128'd1);
    chk("mid_run_busy", 128'(busy), 128'd1);
    rn = 1'b0; #1;
    chk("mid_rst_outs", 128'(w_outs), 128'd0);
    step(); rn = 1'b1;
    step(); q_valid = 1'b1; q_len = 5'd1; #1;
    chk("post_rst_q_refused", 128'(q_ready), 128'd0);
    step(); q_valid = 1'b0; #1;
    chk("post_rst_idle", 128'(busy), 128'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
